stack_mem_port: RTL
===================

# stack_mem_port

- Memory-side stage directly downstream of the processor's stack-pointer unit.
- Accepts a one-cycle stack access request (16-bit address plus push/pop kind) and runs the single read or write on the shared data-RAM port using a req/ack handshake.
- Returns popped data with a one-cycle `read_it` pulse. The stack-pointer unit consumes this pulse to commit its post-pop decrement.
- Suppresses writes flagged as overflow and records faults in a sticky register.

## Interface
Parameters:
- `DATA_W`, 16, stack word width.
- `TIMEOUT`, 255, maximum wait cycles for `mem_ack` (8-bit counter; legal range 1–255).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  one-cycle access request (from the pointer unit's write-enable strobe).
- `addr`  in  16  stack word address, valid with `req`.
- `is_pop`  in  1  1 = pop (read), 0 = push (write); valid with `req`.
- `wdata`  in  DATA_W  push data, valid with `req`.
- `ovf_in`  in  1  pointer-unit overflow/underflow flag, sampled with `req` and whenever high.
- `fault_clr`  in  1  clears `fault`.
- `busy`  out  1  a transaction is in progress.
- `read_it`  out  1  one-cycle pulse: `rdata` is valid and the pop has completed.
- `rdata`  out  DATA_W  popped word; holds its value until the next pop completes.
- `mem_addr`  out  16  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_we`  out  1  write request, held until ack.
- `mem_re`  out  1  read request, held until ack.
- `mem_ack`  in  1  RAM completion; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_W  RAM read data.
- `fault`  out  2  sticky flags. Bit 0: stack over/underflow. Bit 1: bus fault (timeout or collision).

## Operation
- FSM states and transitions:
  - IDLE: `req` with `is_pop`=0 and `ovf_in`=0 → WR. `req` with `is_pop`=1 → RD. `req` with `is_pop`=0 and `ovf_in`=1 → stay IDLE, set `fault[0]`, no RAM cycle.
  - WR: `mem_we`=1. On `mem_ack` → IDLE.
  - RD: `mem_re`=1. On `mem_ack` → DONE; `mem_rdata` is captured into `rdata`.
  - DONE: `read_it`=1 for exactly one cycle → IDLE.
- Entering WR/RD registers `addr` into `mem_addr` and `wdata` into `mem_wdata`. These hold stable until the state is left.
- `busy` = 1 in every state except IDLE.
- `req` while `busy`=1: request is dropped; set `fault[1]`. The in-flight transaction is unaffected.
- `ovf_in`=1 in any cycle (including pop underflow reported by the pointer unit) sets `fault[0]`.
- `mem_ack` outside WR/RD is ignored.
- `fault_clr` clears both bits. If `fault_clr` and a new fault event occur in the same cycle, the set wins.
- Reset values: state IDLE; `busy`, `read_it`, `mem_we`, `mem_re` = 0; `mem_addr`, `mem_wdata`, `rdata` = 0; `fault` = 0; timeout counter = 0.
- Reset mid-transaction: the FSM returns to IDLE immediately (asynchronously), `mem_we`/`mem_re` drop at once, and any pending `read_it` is lost.

## Timing
- Request sampled at edge 0. `mem_we`/`mem_re` high from cycle 1. The earliest legal `mem_ack` is cycle 1.
- Push with ack in cycle k: `busy` falls in cycle k+1. A new `req` is accepted in cycle k+1.
- Pop with ack in cycle k: `rdata` is valid and `read_it`=1 in cycle k+1; `busy` falls in cycle k+2.
- Zero-wait pop latency: `req` at 0 → `read_it` at cycle 2.
- Outputs are registered; there is no combinational path from `req` to any `mem_*` output.

## Configuration
- `STACK_PORT_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WR/RD and increments each cycle without `mem_ack`.
  - On reaching `TIMEOUT`: drop the request, return to IDLE, set `fault[1]`. An aborted pop issues no `read_it`.
- `STACK_PORT_TIMEOUT_EN` undefined:
  - No counter is built; WR/RD wait indefinitely for `mem_ack`.
  - `fault[1]` is set only by collisions.

## Test plan
- Push: `addr`=0x2B05, `wdata`=0xBEEF, ack after 3 wait cycles → `mem_we`=1 with 0x2B05/0xBEEF for cycles 1–4, `busy` low at cycle 5, `read_it` never asserted.
- Pop: `addr`=0x2805, `mem_rdata`=0x1234, zero-wait ack → `mem_re`=1 in cycle 1, `read_it`=1 with `rdata`=0x1234 in cycle 2 only, `busy` low in cycle 3.
- Overflowed push: `req` with `ovf_in`=1 → no `mem_we`, `fault`=2'b01; `fault_clr` → `fault`=0.
- Collision: second `req` during a pending read → ignored, one RAM read only, `fault[1]`=1.
- Timeout (macro defined, `TIMEOUT`=4): pop, no ack → `mem_re` drops after 4 cycles, `fault`=2'b10, no `read_it`.
- Reset: assert `rst` during WR → `mem_we`=0 and `busy`=0 in the same cycle; a new push after release completes normally.

Source files
------------

// File: rtl/stack_mem_port.sv
// Stack memory port: runs one push (write) or pop (read) per request on the shared data-RAM req/ack port.
// Optional macro STACK_PORT_TIMEOUT_EN adds an ack-timeout abort; by default WR/RD wait indefinitely.
module stack_mem_port #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [15:0]       addr,
    input  logic              is_pop,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ovf_in,
    input  logic              fault_clr,
    output logic              busy,
    output logic              read_it,
    output logic [DATA_W-1:0] rdata,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        fault
);

    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DONE
    } state_t;

    // The counter is 8 bits wide, so TIMEOUT must fit in 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("stack_mem_port: TIMEOUT must be in 1..255");
    end

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   mem_addr_nx;
    logic [DATA_W-1:0]   mem_wdata_nx;
    logic [DATA_W-1:0]   rdata_nx;
    logic [1:0]          fault_nx;
    logic                tmo_hit_c;

`ifdef STACK_PORT_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_nx;

    // Abort fires on the cycle the count would reach TIMEOUT with no ack.
    assign tmo_hit_c = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_nx = tmo_cnt;
        if (state == S_IDLE) begin
            tmo_cnt_nx = '0;
        end else if ((state == S_WR || state == S_RD) && !mem_ack) begin
            tmo_cnt_nx = tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_nx;
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next-state, captured payload and sticky fault logic.
    always_comb begin
        state_nx     = state;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        rdata_nx     = rdata;
        fault_nx     = fault_clr ? 2'b00 : fault;

        case (state)
            S_IDLE: begin
                if (req && (is_pop || !ovf_in)) begin
                    state_nx     = is_pop ? S_RD : S_WR;
                    mem_addr_nx  = addr;
                    mem_wdata_nx = wdata;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_nx = S_IDLE;
                end else if (tmo_hit_c) begin
                    state_nx    = S_IDLE;
                    fault_nx[1] = 1'b1;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    state_nx = S_DONE;
                    rdata_nx = mem_rdata;
                end else if (tmo_hit_c) begin
                    state_nx    = S_IDLE;
                    fault_nx[1] = 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Requests arriving while busy are dropped and flagged.
        if (req && state != S_IDLE) begin
            fault_nx[1] = 1'b1;
        end
        if (ovf_in) begin
            fault_nx[0] = 1'b1;
        end
    end

    // State register; outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            read_it   <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            fault     <= 2'b00;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != S_IDLE);
            read_it   <= (state_nx == S_DONE);
            mem_we    <= (state_nx == S_WR);
            mem_re    <= (state_nx == S_RD);
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            rdata     <= rdata_nx;
            fault     <= fault_nx;
        end
    end

endmodule
